// File: rtl/phy_rx_serial_paralelo_if.sv
// Serial receive bundle: the 1-bit line in, the rebuilt byte stream out.
// Master drives the serial bit; slave is the converter.
interface phy_rx_serial_paralelo_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/phy_rx_serial_paralelo.sv
// PHY receive serial-to-parallel: comma-based byte alignment at clk_8f,
// rebuilt bytes with a valid flag; idle commas are dropped.
module phy_rx_serial_paralelo #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    ACTIVE
  } state_t;

  localparam logic [3:0] SYNC_N = SYNC_COUNT[3:0];

  state_t     state_q, state_d;
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;

  logic [7:0] nb;
  logic       is_comma;
  logic       boundary;
  logic [3:0] bc_inc;

  // Only the low 7 bits of history are ever needed to form nb.
  assign nb       = {sr_q, data_in};
  assign is_comma = (nb == COMMA);
  assign boundary = (bit_cnt_q == 3'd7);
  assign bc_inc   = bc_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    sr_d      = nb[6:0];
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;

    unique case (state_q)
      SEARCH: begin
        valid_d = 1'b0;
        if (is_comma) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          if (SYNC_N == 4'd1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        valid_d   = 1'b0;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == SYNC_N) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            state_d   = SEARCH;
            bc_cnt_d  = 4'd0;
            bit_cnt_d = 3'd0;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_d  = nb;
            valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: doc/phy_rx_serial_paralelo.md
Name: phy_rx_serial_paralelo

Overview:
- Receive-side serial-to-parallel converter for the PHY link.
- Takes the 1-bit serial stream produced by the transmit side at clk_8f, MSB first.
- Locks byte alignment on the idle comma 0xBC, then rebuilds 8-bit bytes with a valid flag for the downstream lane demux.
- Idle commas in the stream mean "no valid data" and are never forwarded.

Parameters:
- COMMA, 8'hBC, idle/alignment symbol sent by the transmitter when valid is low.
- SYNC_COUNT, 4, number of consecutive byte-aligned commas required before declaring lock (legal range 1..15).

Ports:
- clk_8f  input  1  serial bit clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  1  serial bit from transmitter, MSB of each byte first.
- data_out  output  8  reconstructed byte, registered.
- valid_out  output  1  high for one byte period when data_out holds a non-comma byte.
- active  output  1  alignment lock indicator.

Behaviour:
- Reset (reset=0, asynchronous): state=SEARCH, shift reg sr=0, bit_cnt=0, bc_cnt=0, data_out=8'h00, valid_out=0, active=0.
- Every clk_8f edge out of reset: sr <= {sr[6:0], data_in}.
- Define nb = {sr[6:0], data_in}, the byte completed by the current bit.
- bit_cnt is 3 bits and wraps 7->0.
- A byte boundary is a cycle with bit_cnt==7 in state ALIGN or ACTIVE.
- SEARCH:
  - Evaluate nb every cycle (bit-sliding search).
  - nb==COMMA -> bit_cnt<=0, bc_cnt<=1. If SYNC_COUNT==1, go to ACTIVE and set active<=1; otherwise go to ALIGN.
  - Otherwise stay in SEARCH.
  - valid_out=0 and data_out holds.
- ALIGN:
  - bit_cnt increments every cycle.
  - At a byte boundary, nb==COMMA -> bc_cnt<=bc_cnt+1. If bc_cnt+1==SYNC_COUNT, go to ACTIVE and set active<=1 on the same edge.
  - At a byte boundary, nb!=COMMA -> go to SEARCH, bc_cnt<=0, bit_cnt<=0. A comma found later restarts the count from 1.
  - valid_out=0.
- ACTIVE:
  - bit_cnt keeps free-running.
  - At a byte boundary, nb!=COMMA -> data_out<=nb, valid_out<=1.
  - At a byte boundary, nb==COMMA -> valid_out<=0, data_out holds its last value.
  - Between boundaries, data_out and valid_out hold. Each output byte is therefore stable for exactly 8 clk_8f cycles.
- Latency: data_out/valid_out update on the same edge that samples the byte's 8th (LSB) bit. They are visible 1 cycle after the last bit is presented on data_in.
- active is sticky: once set it stays 1 until reset. There is no loss-of-sync detection in ACTIVE, and bit errors are passed through as data.
- Comma-like bit patterns straddling byte boundaries:
  - Ignored in ALIGN and ACTIVE (only boundaries are checked).
  - Matched in SEARCH (a false lock attempt is rejected in ALIGN by the next non-comma boundary).
- Reset asserted mid-byte or mid-lock: immediate return to reset values. After release, realignment requires SYNC_COUNT fresh commas.
- No combinational path from data_in to any output.

Test Plan:
- Reset: hold reset=0 for 3 cycles while driving random data_in -> data_out=0x00, valid_out=0, active=0 throughout.
- Lock and data, default SYNC_COUNT=4: send 4x 0xBC then 0x55, 0xA3 -> active=1 on the edge sampling the 4th comma's LSB.
  - data_out=0x55 with valid_out=1 for 8 cycles, then 0xA3 for 8 cycles.
- Misaligned start: 3 garbage bits 1,0,1 then 4x 0xBC, 0x3C -> lock achieved and data_out=0x3C.
  - Bit offset must not corrupt the byte.
- Broken sync: 3x 0xBC, 0x12, then 4x 0xBC, 0x7E -> active stays 0 through 0x12 (no valid_out).
  - Lock occurs only after the second comma run; data_out=0x7E, valid_out=1.
- Idle in ACTIVE: after lock send 0x99, 0xBC, 0x44 -> valid_out 1 (0x99), then 0 with data_out held at 0x99, then 1 (0x44).
- Async reset mid-operation: assert reset at bit 4 of a data byte while active=1 -> all outputs cleared without waiting for a clock edge.
  - After release, 0x66 alone is not output; 4 commas are required before 0x66 appears.
